// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch core.
package stopwatch_pkg;

    // Run/pause control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } swState_e;

    // Highest value of a units digit (BCD 0..9).
    localparam logic [3:0] ONES_MAX = 4'd9;
    // Highest value of a tens digit (0..5).
    localparam logic [2:0] TENS_MAX = 3'd5;

endpackage

// File: rtl/stopwatch_if.sv
// Bundle of the stopwatch button/tick inputs and display outputs.
// Carries the lap button only when STOPWATCH_LAP_EN is defined.
interface stopwatch_if;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
`ifdef STOPWATCH_LAP_EN
    logic       lap;
`endif
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic       running;
    logic       wrap;

    // Side that drives the buttons and watches the display.
    modport master (
`ifdef STOPWATCH_LAP_EN
        output lap,
`endif
        output tick_in, start_stop, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );

    // Side that implements the stopwatch.
    modport slave (
`ifdef STOPWATCH_LAP_EN
        input  lap,
`endif
        input  tick_in, start_stop, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );
endinterface

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus history flop producing a one-cycle rise pulse.
// A short valid shift register keeps the history flop from being trusted
// until it holds a real sample, so a level that is already high when reset
// releases never looks like a rising edge.
module sync_rise (
    input  logic clock_in,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);
    logic       sync1_q;
    logic       sync2_q;
    logic       hist_q;
    logic [2:0] valid_q;

    // Synchronize the asynchronous level and remember the previous sample.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            valid_q <= 3'b000;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            valid_q <= {valid_q[1:0], 1'b1};
        end
    end

    assign rise_o = sync2_q & ~hist_q & valid_q[2];
endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with start/stop and clear buttons driven by a slow tick.
// Optional feature macro STOPWATCH_LAP_EN adds a lap button that freezes
// the displayed digits while the internal count keeps running.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic       clock_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       running,
    output logic       wrap
);
    localparam logic [2:0] MAX_MIN_TENS = 3'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

    logic       tickRise;
    logic       ssRise;
    logic       clrRise;

    swState_e   state_q;
    logic       running_q;

    logic [3:0] secOnes_q, secOnes_d;
    logic [2:0] secTens_q, secTens_d;
    logic [3:0] minOnes_q, minOnes_d;
    logic [2:0] minTens_q, minTens_d;
    logic       wrap_q, wrap_d;

    sync_rise uTickSync (.clock_in(clock_in), .rst_n(rst_n), .async_i(tick_in),    .rise_o(tickRise));
    sync_rise uSsSync   (.clock_in(clock_in), .rst_n(rst_n), .async_i(start_stop), .rise_o(ssRise));
    sync_rise uClrSync  (.clock_in(clock_in), .rst_n(rst_n), .async_i(clear),      .rise_o(clrRise));

    // Run/pause FSM; clear wins over start_stop, running is registered with the state.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (clrRise) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (ssRise) begin
            case (state_q)
                RUN: begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
            endcase
        end
    end

    // BCD cascade: a tick in RUN advances one second; MAX_MIN:59 rolls to 00:00 with wrap.
    always_comb begin
        secOnes_d = secOnes_q;
        secTens_d = secTens_q;
        minOnes_d = minOnes_q;
        minTens_d = minTens_q;
        wrap_d    = 1'b0;
        if (clrRise) begin
            secOnes_d = '0;
            secTens_d = '0;
            minOnes_d = '0;
            minTens_d = '0;
        end else if ((state_q == RUN) && tickRise) begin
            if (secOnes_q != ONES_MAX) begin
                secOnes_d = secOnes_q + 4'd1;
            end else begin
                secOnes_d = '0;
                if (secTens_q != TENS_MAX) begin
                    secTens_d = secTens_q + 3'd1;
                end else begin
                    secTens_d = '0;
                    if ((minTens_q == MAX_MIN_TENS) && (minOnes_q == MAX_MIN_ONES)) begin
                        minOnes_d = '0;
                        minTens_d = '0;
                        wrap_d    = 1'b1;
                    end else if (minOnes_q != ONES_MAX) begin
                        minOnes_d = minOnes_q + 4'd1;
                    end else begin
                        minOnes_d = '0;
                        minTens_d = minTens_q + 3'd1;
                    end
                end
            end
        end
    end

    // Live time digits and the one-cycle wrap pulse.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            secOnes_q <= '0;
            secTens_q <= '0;
            minOnes_q <= '0;
            minTens_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            secOnes_q <= secOnes_d;
            secTens_q <= secTens_d;
            minOnes_q <= minOnes_d;
            minTens_q <= minTens_d;
            wrap_q    <= wrap_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lapRise;
    logic       frozen_q, frozen_d;
    logic [3:0] dispSecOnes_q;
    logic [2:0] dispSecTens_q;
    logic [3:0] dispMinOnes_q;
    logic [2:0] dispMinTens_q;

    sync_rise uLapSync (.clock_in(clock_in), .rst_n(rst_n), .async_i(lap), .rise_o(lapRise));

    // Freeze starts on a lap rise in RUN; a second lap rise or any clear releases it.
    always_comb begin
        frozen_d = frozen_q;
        if (clrRise) begin
            frozen_d = 1'b0;
        end else if (lapRise) begin
            if (frozen_q) begin
                frozen_d = 1'b0;
            end else if (state_q == RUN) begin
                frozen_d = 1'b1;
            end
        end
    end

    // Display copy follows the live count unless frozen; the freezing edge keeps the old value.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            frozen_q      <= 1'b0;
            dispSecOnes_q <= '0;
            dispSecTens_q <= '0;
            dispMinOnes_q <= '0;
            dispMinTens_q <= '0;
        end else begin
            frozen_q <= frozen_d;
            if (!frozen_d) begin
                dispSecOnes_q <= secOnes_d;
                dispSecTens_q <= secTens_d;
                dispMinOnes_q <= minOnes_d;
                dispMinTens_q <= minTens_d;
            end
        end
    end

    assign sec_ones = dispSecOnes_q;
    assign sec_tens = dispSecTens_q;
    assign min_ones = dispMinOnes_q;
    assign min_tens = dispMinTens_q;
`else
    assign sec_ones = secOnes_q;
    assign sec_tens = secTens_q;
    assign min_ones = minOnes_q;
    assign min_tens = minTens_q;
`endif

    assign running = running_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core: two instances (MAX_MIN 59 and 1) share one
// stimulus stream and are compared every cycle against a seconds-count model.
// Honors STOPWATCH_LAP_EN for the lap button.
`timescale 1ns/1ps
module tb_stopwatch_core;
    localparam int MAX_A = 59;
    localparam int MAX_B = 1;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    logic tickDrv = 1'b0;
    logic ssDrv = 1'b0;
    logic clrDrv = 1'b0;
    logic lapDrv = 1'b0;

    int passCnt = 0;
    int totalCnt = 0;
    int failCnt = 0;
    int wrapCountB = 0;

    stopwatch_if swA ();
    stopwatch_if swB ();

    assign swA.tick_in = tickDrv;
    assign swA.start_stop = ssDrv;
    assign swA.clear = clrDrv;
    assign swB.tick_in = tickDrv;
    assign swB.start_stop = ssDrv;
    assign swB.clear = clrDrv;
`ifdef STOPWATCH_LAP_EN
    assign swA.lap = lapDrv;
    assign swB.lap = lapDrv;
`endif

    always #10 clock = ~clock;

    stopwatch_core #(.MAX_MIN(MAX_A)) dutA (
        .clock_in(clock), .rst_n(rst_n),
        .tick_in(swA.tick_in), .start_stop(swA.start_stop), .clear(swA.clear),
`ifdef STOPWATCH_LAP_EN
        .lap(swA.lap),
`endif
        .sec_ones(swA.sec_ones), .sec_tens(swA.sec_tens),
        .min_ones(swA.min_ones), .min_tens(swA.min_tens),
        .running(swA.running), .wrap(swA.wrap)
    );

    stopwatch_core #(.MAX_MIN(MAX_B)) dutB (
        .clock_in(clock), .rst_n(rst_n),
        .tick_in(swB.tick_in), .start_stop(swB.start_stop), .clear(swB.clear),
`ifdef STOPWATCH_LAP_EN
        .lap(swB.lap),
`endif
        .sec_ones(swB.sec_ones), .sec_tens(swB.sec_tens),
        .min_ones(swB.min_ones), .min_tens(swB.min_tens),
        .running(swB.running), .wrap(swB.wrap)
    );

    // Behavioural model: time as a plain seconds count, control as an abstract mode.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mMode_e;
    mMode_e mMode [2] = '{M_IDLE, M_IDLE};
    int     mCnt [2] = '{0, 0};
    int     mDisp [2] = '{0, 0};
    bit     mWrap [2] = '{1'b0, 1'b0};
    bit     mFrozen [2] = '{1'b0, 1'b0};
    int     mLimit [2] = '{(MAX_A + 1) * 60, (MAX_B + 1) * 60};
    logic [3:0] inHist [4] = '{4'b0, 4'b0, 4'b0, 4'b0};
    int     edgeCnt = 0;

    task automatic modelStep();
        bit ev [4];
        mMode_e old;
        inHist[0] = {inHist[0][2:0], tickDrv};
        inHist[1] = {inHist[1][2:0], ssDrv};
        inHist[2] = {inHist[2][2:0], clrDrv};
        inHist[3] = {inHist[3][2:0], lapDrv};
        edgeCnt++;
        // An input that rose is acted on at the 3rd edge that sampled it high.
        for (int i = 0; i < 4; i++) ev[i] = (edgeCnt >= 4) && inHist[i][2] && !inHist[i][3];
        for (int k = 0; k < 2; k++) begin
            old = mMode[k];
            mWrap[k] = 1'b0;
            if (ev[2]) begin
                mMode[k] = M_IDLE;
                mCnt[k] = 0;
                mFrozen[k] = 1'b0;
            end else begin
                if (old == M_RUN && ev[0]) begin
                    mCnt[k] = mCnt[k] + 1;
                    if (mCnt[k] == mLimit[k]) begin
                        mCnt[k] = 0;
                        mWrap[k] = 1'b1;
                    end
                end
                if (ev[3]) begin
                    if (mFrozen[k]) mFrozen[k] = 1'b0;
                    else if (old == M_RUN) mFrozen[k] = 1'b1;
                end
                if (ev[1]) mMode[k] = (old == M_RUN) ? M_PAUSE : M_RUN;
            end
            if (!mFrozen[k]) mDisp[k] = mCnt[k];
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge rst_n);
            if (!rst_n) begin
                edgeCnt = 0;
                for (int i = 0; i < 4; i++) inHist[i] = 4'b0;
                for (int k = 0; k < 2; k++) begin
                    mMode[k] = M_IDLE;
                    mCnt[k] = 0;
                    mDisp[k] = 0;
                    mWrap[k] = 1'b0;
                    mFrozen[k] = 1'b0;
                end
            end else begin
                modelStep();
            end
        end
    end

    function automatic logic [15:0] expVec(int k);
        int d;
        d = mDisp[k];
        return {3'(d / 600), 4'((d / 60) % 10), 3'((d % 60) / 10), 4'(d % 10),
                (mMode[k] == M_RUN), mWrap[k]};
    endfunction

    function automatic logic [15:0] vecA();
        return {swA.min_tens, swA.min_ones, swA.sec_tens, swA.sec_ones, swA.running, swA.wrap};
    endfunction

    function automatic logic [15:0] vecB();
        return {swB.min_tens, swB.min_ones, swB.sec_tens, swB.sec_ones, swB.running, swB.wrap};
    endfunction

    function automatic int timeA();
        return int'(swA.min_tens) * 600 + int'(swA.min_ones) * 60 + int'(swA.sec_tens) * 10 + int'(swA.sec_ones);
    endfunction

    function automatic int timeB();
        return int'(swB.min_tens) * 600 + int'(swB.min_ones) * 60 + int'(swB.sec_tens) * 10 + int'(swB.sec_ones);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) begin
            passCnt++;
        end else begin
            failCnt++;
            $display("[TB] FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Every-cycle compare of both instances against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (rst_n && edgeCnt > 0) begin
                checkOutput("cycle_A", int'(vecA()), int'(expVec(0)));
                checkOutput("cycle_B", int'(vecB()), int'(expVec(1)));
            end
        end
    end

    // Counts wrap-high cycles of the MAX_MIN=1 instance.
    initial begin
        forever begin
            @(negedge clock);
            if (rst_n && swB.wrap) wrapCountB++;
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: actual timeout, required finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic t, input logic s, input logic c, input logic l, input int hold);
        tickDrv = t;
        ssDrv = s;
        clrDrv = c;
        lapDrv = l & LAP_EN;
        waitCycles(hold);
    endtask

    task automatic tickPulse();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tickPulse();
    endtask

    task automatic pressSS();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
    endtask

    task automatic pressClr();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
    endtask

    task automatic pressLap();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
    endtask

    initial begin
        int wrapBefore;
        // Reset with tick and start_stop already high.
        tickDrv = 1'b1;
        ssDrv = 1'b1;
        #2 rst_n = 1'b0;
        waitCycles(3);
        checkOutput("reset_A", int'(vecA()), 0);
        checkOutput("reset_B", int'(vecB()), 0);
        @(negedge clock);
        rst_n = 1'b1;
        waitCycles(12);
        checkOutput("no_rise_after_reset_time", timeA(), 0);
        checkOutput("no_rise_after_reset_running", int'(swA.running), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6);

        $display("[TB] start and first three ticks");
        pressSS();
        checkOutput("running_after_start", int'(swA.running), 1);
        for (int i = 1; i <= 3; i++) begin
            tickDrv = 1'b1;
            waitCycles(2);
            checkOutput("tick_not_yet_edge2", timeA(), i - 1);
            waitCycles(1);
            checkOutput("tick_update_edge3", timeA(), i);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
        end
        checkOutput("time_00_03", timeA(), 3);
        checkOutput("running_00_03", int'(swA.running), 1);

        $display("[TB] seconds and minutes carries");
        ticks(56);
        checkOutput("time_00_59", timeA(), 59);
        tickPulse();
        checkOutput("time_01_00_A", timeA(), 60);
        checkOutput("time_01_00_B", timeB(), 60);
        ticks(59);
        checkOutput("time_01_59_B", timeB(), 119);
        wrapBefore = wrapCountB;
        tickPulse();
        checkOutput("wrap_B_time", timeB(), 0);
        checkOutput("wrap_B_pulse_cycles", wrapCountB - wrapBefore, 1);
        checkOutput("wrap_B_running", int'(swB.running), 1);
        checkOutput("time_02_00_A", timeA(), 120);
        ticks(479);
        checkOutput("time_09_59", timeA(), 599);
        checkOutput("model_09_59", mDisp[0], 599);
        tickPulse();
        checkOutput("time_10_00", timeA(), 600);

        $display("[TB] pause behaviour");
        pressClr();
        checkOutput("clear_time", timeA(), 0);
        checkOutput("clear_running", int'(swA.running), 0);
        pressSS();
        ticks(5);
        checkOutput("time_00_05", timeA(), 5);
        pressSS();
        checkOutput("paused_running", int'(swA.running), 0);
        ticks(4);
        checkOutput("paused_time", timeA(), 5);
        pressSS();
        tickPulse();
        checkOutput("resume_time", timeA(), 6);
        checkOutput("resume_running", int'(swA.running), 1);

        $display("[TB] coincident clear, start_stop and tick");
        pressClr();
        pressSS();
        ticks(30);
        checkOutput("time_00_30", timeA(), 30);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
        checkOutput("coincident_clear_time", timeA(), 0);
        checkOutput("coincident_clear_running", int'(swA.running), 0);
        checkOutput("coincident_clear_wrap", int'(swA.wrap), 0);

        $display("[TB] tick with start_stop in RUN");
        pressSS();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
        checkOutput("tick_and_pause_time", timeA(), 1);
        checkOutput("tick_and_pause_running", int'(swA.running), 0);

        $display("[TB] randomized stimulus");
        pressSS();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0),
                          1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 9) == 0),
                          int'($urandom_range(1, 4)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6);

`ifdef STOPWATCH_LAP_EN
        $display("[TB] lap freeze");
        pressClr();
        pressSS();
        ticks(10);
        pressLap();
        ticks(5);
        checkOutput("lap_frozen_time", timeA(), 10);
        checkOutput("lap_frozen_running", int'(swA.running), 1);
        pressLap();
        checkOutput("lap_released_time", timeA(), 15);
`endif

        $display("[TB] asynchronous reset while running");
        pressClr();
        pressSS();
        ticks(2);
        checkOutput("pre_reset_time", timeA(), 2);
        @(posedge clock);
        #5 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_A", int'(vecA()), 0);
        checkOutput("async_reset_B", int'(vecB()), 0);
        waitCycles(2);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
